msrv32_imm_decode_ctrl: RTL and testbench

//  Decode-stage controller that drives the immediate generator. Accepts fetched

---
 rtl/msrv32_imm_decode_ctrl_if.sv | 30 +++
 rtl/msrv32_imm_decode_ctrl.sv | 106 ++++++++++
 tb/tb_msrv32_imm_decode_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/msrv32_imm_decode_ctrl_if.sv
// msrv32_imm_decode_ctrl_if: handshake bundle between fetch, the decode controller and execute
//   instr_in/instr_valid_in/instr_ready_out : fetch -> controller valid/ready
//   dec_valid_out/dec_ready_in              : controller -> execute valid/ready
//   instr_out/imm_type_out/uses_imm_out/illegal_out : decoded head entry
//   illegal_cnt_out                         : saturating illegal-instruction count
//   slave modport is the controller side, master modport is the environment side
interface msrv32_imm_decode_ctrl_if #(
    parameter int CNT_W = 8
);
    logic [31:0]      instr_in;
    logic             instr_valid_in;
    logic             instr_ready_out;
    logic             dec_valid_out;
    logic             dec_ready_in;
    logic [24:0]      instr_out;
    logic [2:0]       imm_type_out;
    logic             uses_imm_out;
    logic             illegal_out;
    logic [CNT_W-1:0] illegal_cnt_out;
    modport slave (
        input  instr_in, instr_valid_in, dec_ready_in,
        output instr_ready_out, dec_valid_out, instr_out, imm_type_out,
               uses_imm_out, illegal_out, illegal_cnt_out
    );
    modport master (
        output instr_in, instr_valid_in, dec_ready_in,
        input  instr_ready_out, dec_valid_out, instr_out, imm_type_out,
               uses_imm_out, illegal_out, illegal_cnt_out
    );
endinterface

// File: rtl/msrv32_imm_decode_ctrl.sv
// msrv32_imm_decode_ctrl: decode-stage controller classifying opcodes into immediate formats
//   clk_in   : clock, rising edge
//   rst_n_in : asynchronous active-low reset
//   flush_in : drop all buffered instructions, priority over every handshake
//   bus      : fetch/execute handshakes and decoded outputs (slave modport)
//   SKID_EN=1 gives a 2-entry skid buffer with registered instr_ready_out;
//   SKID_EN=0 keeps only the head entry with combinational ready.
module msrv32_imm_decode_ctrl #(
    parameter bit          SKID_EN     = 1'b1,
    parameter logic [31:0] RESET_INSTR = 32'h0000_0013,
    parameter int          CNT_W       = 8
) (
    input logic                      clk_in,
    input logic                      rst_n_in,
    input logic                      flush_in,
    msrv32_imm_decode_ctrl_if.slave  bus
);
    typedef struct packed {
        logic [24:0] instr;
        logic [2:0]  imm_type;
        logic        uses_imm;
        logic        illegal;
    } entry_t;
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    function automatic entry_t decode(input logic [31:0] i);
        entry_t e;
        e.instr    = i[31:7];
        e.imm_type = 3'b000;
        e.uses_imm = 1'b1;
        e.illegal  = 1'b0;
        if (i[1:0] != 2'b11) begin
            e.uses_imm = 1'b0;
            e.illegal  = 1'b1;
        end else begin
            case (i[6:2])
                5'b00100:          e.imm_type = 3'b000;
                5'b00000:          e.imm_type = 3'b001;
                5'b01000:          e.imm_type = 3'b010;
                5'b11000:          e.imm_type = 3'b011;
                5'b01101, 5'b00101: e.imm_type = 3'b100;
                5'b11011:          e.imm_type = 3'b101;
                5'b11001:          e.imm_type = 3'b111;
                5'b11100:          e.imm_type = i[14] ? 3'b110 : 3'b000;
                5'b01100, 5'b00011: e.uses_imm = 1'b0;
                default: begin
                    e.uses_imm = 1'b0;
                    e.illegal  = 1'b1;
                end
            endcase
        end
        return e;
    endfunction
    localparam entry_t           ENTRY_RST = decode(RESET_INSTR);
    localparam logic [CNT_W-1:0] CNT_ONE   = 1;
    state_t           r_state, w_next;
    entry_t           r_head, r_skid, w_new;
    logic             r_ready, w_ready, w_in, w_out;
    logic             w_head_new, w_head_skid, w_skid_new;
    logic [CNT_W-1:0] r_cnt;
    assign w_new = decode(bus.instr_in);
    // Without the skid entry, accepting is only safe when the head frees up this cycle.
    assign w_ready     = SKID_EN ? r_ready : (r_state == EMPTY || bus.dec_ready_in);
    assign w_in        = bus.instr_valid_in & w_ready;
    assign w_out       = (r_state != EMPTY) & bus.dec_ready_in;
    assign w_head_new  = !flush_in && w_in && (r_state == EMPTY || (r_state == ONE && w_out));
    assign w_head_skid = !flush_in && r_state == TWO && w_out;
    assign w_skid_new  = !flush_in && r_state == ONE && w_in && !w_out;
    always_comb begin
        w_next = r_state;
        if (flush_in) w_next = EMPTY;
        else case (r_state)
            EMPTY:   w_next = w_in ? ONE : EMPTY;
            ONE:     w_next = (w_in && !w_out) ? TWO : (!w_in && w_out) ? EMPTY : ONE;
            TWO:     w_next = w_out ? ONE : TWO;
            default: w_next = EMPTY;
        endcase
    end
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= EMPTY;
            r_ready <= 1'b1;
            r_head  <= ENTRY_RST;
            r_skid  <= ENTRY_RST;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next != TWO);
            if (flush_in) begin
                r_head <= ENTRY_RST;
                r_skid <= ENTRY_RST;
            end else begin
                if (w_head_new) r_head <= w_new;
                else if (w_head_skid) r_head <= r_skid;
                if (w_skid_new) r_skid <= w_new;
            end
            if (w_in && !flush_in && w_new.illegal && r_cnt != '1) r_cnt <= r_cnt + CNT_ONE;
        end
    end
    assign bus.instr_ready_out = w_ready;
    assign bus.dec_valid_out   = (r_state != EMPTY);
    assign bus.instr_out       = r_head.instr;
    assign bus.imm_type_out    = r_head.imm_type;
    assign bus.uses_imm_out    = r_head.uses_imm;
    assign bus.illegal_out     = r_head.illegal;
    assign bus.illegal_cnt_out = r_cnt;
endmodule

// File: tb/tb_msrv32_imm_decode_ctrl.sv
// tb_msrv32_imm_decode_ctrl: scoreboard bench driving a skid (dut0) and a no-skid (dut1) controller
module tb_msrv32_imm_decode_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        valid = 1'b0;
    logic        dready = 1'b0;
    logic [31:0] instr = 32'h0000_0013;
    int          total = 0;
    int          bad = 0;
    logic [6:0]  op_tab [11] = '{7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h73, 7'h33, 7'h0F};
    int          ty_tab [11] = '{0, 1, 2, 3, 4, 4, 5, 7, 6, 0, 0};
    logic [31:0] dir_ins [8] = '{32'h00500093, 32'h00002003, 32'h00112023, 32'h00208463,
                                 32'h000010B7, 32'h008000EF, 32'h000080E7, 32'h3400D073};
    int          dir_ty [8] = '{0, 1, 2, 3, 4, 5, 7, 6};
    always #5 clk = ~clk;
    msrv32_imm_decode_ctrl_if #(.CNT_W(8)) bus [2] ();
    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0h want %0h at %0t", nm, d, act, exp, $time);
        end
    endtask
    // Reference decode: look the opcode up in the format table; anything absent is illegal.
    function automatic logic [29:0] ref_entry(input logic [31:0] x);
        int t;
        for (int k = 0; k < 11; k++)
            if (x[6:0] == op_tab[k]) begin
                t = (op_tab[k] == 7'h73 && !x[14]) ? 0 : ty_tab[k];
                return {x[31:7], t[2:0], k < 9, 1'b0};
            end
        return {x[31:7], 3'b000, 1'b0, 1'b1};
    endfunction
    for (genvar g = 0; g < 2; g++) begin : gen_dut
        assign bus[g].instr_in       = instr;
        assign bus[g].instr_valid_in = valid;
        assign bus[g].dec_ready_in   = dready;
        msrv32_imm_decode_ctrl #(.SKID_EN(g == 0), .RESET_INSTR(32'h0000_0013), .CNT_W(8)) u_dut (
            .clk_in  (clk),
            .rst_n_in(rst_n),
            .flush_in(flush),
            .bus     (bus[g])
        );
        logic [29:0] q [$];
        int          mcnt;
        logic [29:0] e;
        always @(negedge clk) begin
            if (!rst_n) begin
                q.delete();
                mcnt = 0;
            end else begin
                chk("mon_valid", g, 32'(bus[g].dec_valid_out), 32'(q.size() != 0));
                chk("mon_ready", g, 32'(bus[g].instr_ready_out),
                    32'((g == 0) ? (q.size() < 2) : (q.size() == 0 || dready)));
                chk("mon_cnt", g, 32'(bus[g].illegal_cnt_out), mcnt);
                if (flush) q.delete();
                else begin
                    if (bus[g].dec_valid_out && dready && q.size() > 0) begin
                        e = q.pop_front();
                        chk("mon_entry", g, 32'({bus[g].instr_out, bus[g].imm_type_out,
                            bus[g].uses_imm_out, bus[g].illegal_out}), 32'(e));
                    end
                    if (valid && bus[g].instr_ready_out) begin
                        e = ref_entry(instr);
                        q.push_back(e);
                        if (e[0] && mcnt < 255) mcnt++;
                    end
                end
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    initial begin
        logic        acc;
        logic [31:0] r;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_valid", 0, 32'(bus[0].dec_valid_out), 0);
        chk("rst_ready", 0, 32'(bus[0].instr_ready_out), 1);
        chk("rst_instr", 0, 32'(bus[0].instr_out), 0);
        chk("rst_type", 0, 32'(bus[0].imm_type_out), 0);
        chk("rst_uses", 0, 32'(bus[0].uses_imm_out), 1);
        chk("rst_cnt", 0, 32'(bus[0].illegal_cnt_out), 0);
        dready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            instr = dir_ins[i];
            valid = 1'b1;
            tick();
            valid = 1'b0;
            chk("dir_valid", 0, 32'(bus[0].dec_valid_out), 1);
            chk("dir_type", 0, 32'(bus[0].imm_type_out), dir_ty[i]);
        end
        tick();
        dready = 1'b0;
        instr = 32'h00100093;
        valid = 1'b1;
        tick();
        instr = 32'h00202103;
        tick();
        instr = 32'h00312223;
        chk("bp_ready", 0, 32'(bus[0].instr_ready_out), 0);
        tick();
        chk("bp_hold", 0, 32'(bus[0].instr_ready_out), 0);
        dready = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 8 && !acc; k++) begin
            acc = bus[0].instr_ready_out;
            tick();
        end
        chk("bp_accept", 0, 32'(acc), 1);
        valid = 1'b0;
        repeat (4) tick();
        chk("bp_drained", 0, 32'(bus[0].dec_valid_out), 0);
        dready = 1'b0;
        instr = 32'h00500093;
        valid = 1'b1;
        tick();
        instr = 32'h00600113;
        tick();
        instr = 32'h0000007F;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        valid = 1'b0;
        chk("fl_valid", 0, 32'(bus[0].dec_valid_out), 0);
        chk("fl_ready", 0, 32'(bus[0].instr_ready_out), 1);
        chk("fl_instr", 0, 32'(bus[0].instr_out), 0);
        chk("fl_cnt", 0, 32'(bus[0].illegal_cnt_out), 0);
        instr = 32'h00500093;
        valid = 1'b1;
        tick();
        instr = 32'h0000007F;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        valid = 1'b0;
        chk("fl1_valid", 0, 32'(bus[0].dec_valid_out), 0);
        chk("fl1_cnt", 0, 32'(bus[0].illegal_cnt_out), 0);
        chk("fl1_cnt", 1, 32'(bus[1].illegal_cnt_out), 0);
        dready = 1'b1;
        instr = 32'h0000007F;
        valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 10) begin
                chk("ill_flag", 0, 32'(bus[0].illegal_out), 1);
                chk("ill_uses", 0, 32'(bus[0].uses_imm_out), 0);
            end
            if (i == 253) chk("ill_cnt254", 0, 32'(bus[0].illegal_cnt_out), 254);
            if (i == 254) chk("ill_cnt255", 0, 32'(bus[0].illegal_cnt_out), 255);
        end
        valid = 1'b0;
        tick();
        chk("ill_sat", 0, 32'(bus[0].illegal_cnt_out), 255);
        chk("ill_sat", 1, 32'(bus[1].illegal_cnt_out), 255);
        chk("ill_hold", 0, 32'(bus[0].illegal_out), 1);
        dready = 1'b0;
        instr = 32'h00500093;
        valid = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 0, 32'(bus[0].dec_valid_out), 0);
        chk("mrst_ready", 0, 32'(bus[0].instr_ready_out), 1);
        chk("mrst_cnt", 0, 32'(bus[0].illegal_cnt_out), 0);
        tick();
        valid = 1'b0;
        rst_n = 1'b1;
        tick();
        for (int c = 0; c < 3000; c++) begin
            valid  = (c < 400) ? 1'b1 : ($urandom_range(0, 3) != 0);
            dready = (c < 400) ? 1'b1 : ($urandom_range(0, 2) != 0);
            flush  = (c >= 400) && ($urandom_range(0, 39) == 0);
            r      = $urandom;
            instr  = ($urandom_range(0, 4) == 0) ? r : {r[31:7], op_tab[$urandom_range(0, 10)]};
            if (c > 0 && c < 400) begin
                chk("tput_ready", 0, 32'(bus[0].instr_ready_out), 1);
                chk("tput_ready", 1, 32'(bus[1].instr_ready_out), 1);
            end
            tick();
        end
        valid = 1'b0;
        flush = 1'b0;
        dready = 1'b1;
        repeat (5) tick();
        chk("end_empty", 0, 32'(bus[0].dec_valid_out), 0);
        chk("end_empty", 1, 32'(bus[1].dec_valid_out), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
